// File: rtl/dmem_ctrl_pkg.sv
// Shared types and default sizes for the data-memory access controller.
//   state_t     : controller FSM state encoding (2 bits)
//   *_DEF       : default address/data/counter widths and wait timeout
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/dmem_access_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears the count
//   inc_i  : add one this cycle
//   cnt_o  : current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM stage.
// Launches one req/ack transaction per load/store, stalls the pipeline while
// it is outstanding, returns load data for one cycle, and keeps saturating
// counters of hazard stalls, flushes and memory-stall cycles.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   start_i                      : CPU run enable
//   mem_read_i/mem_write_i       : EX/MEM access type
//   addr_i/wdata_i               : EX/MEM address and store data
//   hazard_stall_i/flush_i       : events counted by the perf counters
//   mem_req_o/we/addr/wdata      : request side of the data memory
//   mem_ack_i/mem_rdata_i        : completion pulse and load data
//   stall_o                      : pipeline-wide freeze
//   rdata_o/rdata_valid_o        : captured load data for MEM/WB
//   err_o                        : sticky wait-timeout error
//   *_cnt_o                      : performance counters
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no access outstanding; stall_o follows an incoming access
// WAIT    | request held on the memory bus until ack or timeout
// DONE    | one cycle: pipeline advances, load data valid
// ERROR   | memory never answered; pipeline frozen until reset
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              hazard_stall_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  memstall_cnt_o
);

  // Last WAIT count before giving up; unused when the timeout is disabled.
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic              w_acc, w_stall;
  logic [31:0]       r_to_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  assign w_acc = start_i & (mem_read_i | mem_write_i);

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Combinational so the access is frozen in the cycle it shows up.
        w_stall = w_acc;
        if (w_acc) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (mem_ack_i) begin
          w_state_nxt = ST_DONE;
        end else if ((TIMEOUT != 0) && (r_to_cnt == TO_LAST)) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ERROR: w_stall = 1'b1;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_to_cnt <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
            // A simultaneous read+write is treated as a write.
            r_we     <= mem_write_i;
            r_to_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_ack_i) begin
            if (!r_we) r_rdata <= mem_rdata_i;
          end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Request and error decode straight from state so reset drops them at once.
  assign mem_req_o     = (r_state == ST_WAIT);
  assign err_o         = (r_state == ST_ERROR);
  assign rdata_valid_o = (r_state == ST_DONE) & ~r_we;
  assign stall_o       = w_stall;
  assign mem_we_o      = r_we;
  assign mem_addr_o    = r_addr;
  assign mem_wdata_o   = r_wdata;
  assign rdata_o       = r_rdata;

  // All counters freeze while the CPU is not running; hazard and flush
  // events hidden behind a memory stall are not counted.
  logic w_inc_hz, w_inc_fl, w_inc_ms;
  assign w_inc_hz = start_i & hazard_stall_i & ~w_stall;
  assign w_inc_fl = start_i & flush_i & ~w_stall;
  assign w_inc_ms = start_i & w_stall;

  sat_counter #(.W(CNT_W)) u_cnt_hz (
    .clk_i (clk_i), .rst_i (rst_i), .inc_i (w_inc_hz), .cnt_o (stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_cnt_fl (
    .clk_i (clk_i), .rst_i (rst_i), .inc_i (w_inc_fl), .cnt_o (flush_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_cnt_ms (
    .clk_i (clk_i), .rst_i (rst_i), .inc_i (w_inc_ms), .cnt_o (memstall_cnt_o)
  );

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic        hazard_stall_i = 1'b0, flush_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0, mem_rdata_i = '0;

  logic        mem_req_o, mem_we_o, stall_o, rdata_valid_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;
  logic [31:0] stall_cnt_o, flush_cnt_o, memstall_cnt_o;

  logic        s_req, s_we, s_stall, s_valid, s_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  s_stall_cnt, s_flush_cnt, s_memstall_cnt;

  always #5 clk_i = ~clk_i;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .hazard_stall_i(hazard_stall_i), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .err_o(err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .memstall_cnt_o(memstall_cnt_o)
  );

  // Narrow-counter instance fed the same stimulus, used for saturation.
  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(2), .TIMEOUT(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .hazard_stall_i(hazard_stall_i), .flush_i(flush_i),
    .mem_req_o(s_req), .mem_we_o(s_we),
    .mem_addr_o(s_addr), .mem_wdata_o(s_wdata),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(s_stall), .rdata_o(s_rdata), .rdata_valid_o(s_valid),
    .err_o(s_err), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt),
    .memstall_cnt_o(s_memstall_cnt)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  req_t        cur;
  logic        prev_req = 1'b0;
  int          req_rises = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected requests on each req rise and expected load data
  // on each rdata_valid_o, independent of the stimulus thread.
  always @(negedge clk_i) begin
    if (mem_req_o && !prev_req) begin
      req_rises++;
      if (req_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL req_unexpected: got req=1 expected no request");
      end else begin
        cur = req_q.pop_front();
      end
    end
    if (mem_req_o) begin
      chk("req_we", mem_we_o, cur.we);
      chk("req_addr", mem_addr_o, cur.addr);
      chk("req_wdata", mem_wdata_o, cur.wdata);
    end
    if (rdata_valid_o) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdata_unexpected: got valid=1 expected valid=0");
      end else begin
        chk("rdata_sb", rdata_o, rd_q.pop_front());
      end
    end
    prev_req = mem_req_o;
  end

  task automatic push_req(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    req_t e;
    e.we    = wr;
    e.addr  = a;
    e.wdata = wd;
    req_q.push_back(e);
  endtask

  // One access: IDLE cycle, lat WAIT cycles (ack in the last), then DONE.
  // Inputs stay present through DONE, as they would in the real pipeline.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rdat,
                           input int lat, input logic fl);
    int n;
    n = 0;
    @(posedge clk_i); #1;
    start_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
    addr_i = a; wdata_i = wd; flush_i = fl;
    push_req(wr, a, wd);
    if (rd && !wr) rd_q.push_back(rdat);
    @(negedge clk_i);
    if (stall_o) n++;
    chk("idle_no_req", mem_req_o, 1'b0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk_i); #1;
      flush_i     = 1'b0;
      mem_ack_i   = (k == lat);
      mem_rdata_i = (k == lat) ? rdat : 32'hBAD0_BAD0;
      @(negedge clk_i);
      if (stall_o) n++;
      if (k == 1) chk("req_up", mem_req_o, 1'b1);
    end
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; mem_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk_i);
    if (stall_o) n++;
    chk("done_req_low", mem_req_o, 1'b0);
    chk("done_valid", rdata_valid_o, rd & ~wr);
    chk("stall_cycles", n, lat + 1);
  endtask

  task automatic go_idle();
    @(posedge clk_i); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0; flush_i = 1'b0; hazard_stall_i = 1'b0;
    @(negedge clk_i);
    chk("idle_after", {mem_req_o, stall_o}, 2'b00);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i); #2;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  initial begin
    int r0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ctrl", {mem_req_o, mem_we_o, stall_o, rdata_valid_o, err_o}, 5'b0);
    chk("rst_bus", {mem_addr_o, mem_wdata_o}, 64'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_cnt", {stall_cnt_o, flush_cnt_o}, 64'h0);
    chk("rst_memstall", memstall_cnt_o, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; start_i = 1'b1;

    // lw, ack on the third WAIT cycle
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h0000_0005, 3, 1'b0);
    chk("lw_rdata", rdata_o, 32'h5);
    chk("lw_memstall", memstall_cnt_o, 32'd4);
    go_idle();

    // sw, ack on the first WAIT cycle; load data must not be captured
    do_access(1'b0, 1'b1, 32'h0C, 32'hDEAD_BEEF, 32'h7777_7777, 1, 1'b0);
    chk("sw_keep_rdata", rdata_o, 32'h5);
    go_idle();

    // read and write together behave as a write
    do_access(1'b1, 1'b1, 32'h20, 32'h1111_2222, 32'h3333_4444, 2, 1'b0);
    chk("rw_keep_rdata", rdata_o, 32'h5);
    go_idle();

    // back-to-back lw then sw
    r0 = req_rises;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 2, 1'b0);
    do_access(1'b0, 1'b1, 32'h14, 32'hA5A5_A5A5, 32'h0, 2, 1'b0);
    go_idle();
    @(negedge clk_i);
    chk("b2b_req_pulses", req_rises - r0, 2);
    chk("b2b_rdata", rdata_o, 32'h1234_5678);

    // counters: 5 hazard cycles, one visible flush, one flush under a stall
    pulse_reset();
    @(negedge clk_i);
    chk("cnt_cleared", {stall_cnt_o, flush_cnt_o}, 64'h0);
    @(posedge clk_i); #1;
    hazard_stall_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    hazard_stall_i = 1'b0; flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 32'h0000_0099, 1, 1'b1);
    go_idle();
    chk("hz_cnt32", stall_cnt_o, 32'd5);
    chk("hz_sat", s_stall_cnt, 2'd3);
    chk("fl_cnt32", flush_cnt_o, 32'd1);
    chk("fl_sat", s_flush_cnt, 2'd1);
    chk("ms_cnt32", memstall_cnt_o, 32'd2);

    // reset pulsed in the middle of WAIT
    @(posedge clk_i); #1;
    mem_read_i = 1'b1; addr_i = 32'h80;
    push_req(1'b0, 32'h80, wdata_i);
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("midwait_req", mem_req_o, 1'b1);
    #1 rst_i = 1'b1;
    #1;
    chk("rst_async_req", mem_req_o, 1'b0);
    chk("rst_async_cnt", {stall_cnt_o, memstall_cnt_o}, 64'h0);
    mem_read_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("post_rst_idle", {mem_req_o, stall_o, err_o}, 3'b000);
    chk("post_rst_cnt", {flush_cnt_o, memstall_cnt_o}, 64'h0);

    // timeout: ack never comes, ERROR after 4 WAIT cycles
    @(posedge clk_i); #1;
    mem_read_i = 1'b1; addr_i = 32'h90;
    push_req(1'b0, 32'h90, wdata_i);
    @(negedge clk_i);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      chk("to_wait", {mem_req_o, stall_o, err_o}, 3'b110);
    end
    @(negedge clk_i);
    chk("to_err", {mem_req_o, stall_o, err_o}, 3'b011);
    @(posedge clk_i); #1;
    mem_read_i = 1'b0; mem_ack_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("err_sticky", {stall_o, err_o, rdata_valid_o, mem_req_o}, 4'b1100);
    #1 rst_i = 1'b1;
    #1;
    chk("err_rst_async", {stall_o, err_o}, 2'b00);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    chk("sb_drained", req_q.size() + rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
